instruction_encoder: RTL

INSTRUCTION_ENCODER -- requirements
Module: instruction_encoder

---
 rtl/instruction_encoder.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/instruction_encoder.sv
// Packs instruction field bundles into 32-bit words and streams them to
// consecutive memory addresses through a small output FIFO.
module instruction_encoder #(
  parameter int DEPTH  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic              in_last_i,
  input  logic [1:0]        type_i,
  input  logic [4:0]        op_i,
  input  logic [4:0]        rs_i,
  input  logic [4:0]        rt_i,
  input  logic [4:0]        rd_i,
  input  logic [9:0]        shamt_i,
  input  logic [15:0]       imm_i,
  input  logic [28:0]       address_i,
  input  logic [4:0]        r0_i,
  input  logic [4:0]        f0_i,
  input  logic [4:0]        f1_i,
  input  logic [4:0]        f2_i,
  output logic              wr_valid_o,
  input  logic              wr_ready_i,
  output logic [ADDR_W-1:0] wr_addr_o,
  output logic [31:0]       wr_data_o,
  output logic              done_o,
  output logic              err_o,
  output logic [15:0]       instr_count_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [31:0]       mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [31:0]       wr_data_q, wr_data_d;
  logic [15:0]       icount_q, icount_d;
  logic              err_q, err_d;

  logic [31:0] word;
  logic        illegal;
  logic        full;
  logic        accept;
  logic        push;
  logic        pop;

  always_comb begin
    word    = '0;
    illegal = 1'b0;
    case (type_i)
      2'd0: word = {type_i, op_i, rs_i, rt_i, rd_i, shamt_i};
      2'd1: begin
        word    = {type_i, op_i, rs_i, rt_i, imm_i[14:0]};
        illegal = (imm_i[15] != imm_i[14]);
      end
      2'd2: begin
        word    = {type_i, op_i[0], address_i};
        illegal = |op_i[4:1];
      end
      default: begin
        word    = {type_i, op_i[3:0], r0_i, f0_i, f1_i, f2_i, 6'd0};
        illegal = op_i[4];
      end
    endcase
  end

  assign full       = (count_q == CNT_W'(DEPTH));
  assign in_ready_o = (state_q == S_LOAD) && !full;
  assign wr_valid_o = (count_q != '0);
  assign accept     = in_valid_i && in_ready_o;
  assign push       = accept && !illegal;
  assign pop        = wr_valid_o && wr_ready_i;

  assign wr_addr_o     = wr_addr_q;
  assign wr_data_o     = wr_data_q;
  assign instr_count_o = icount_q;
  assign err_o         = err_q;
  assign done_o        = (state_q == S_DRAIN) && (count_q == '0);

  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    icount_d  = icount_q;
    err_d     = err_q;

    if (pop) begin
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      count_d   = count_q - CNT_W'(1);
      wr_addr_d = wr_addr_q + ADDR_W'(1);
      icount_d  = icount_q + 16'd1;
    end
    if (push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = count_d + CNT_W'(1);
    end

    // wr_data is a register holding the FIFO head: the new word when nothing
    // older remains, otherwise the next stored entry after a pop.
    if (push && (count_q == CNT_W'(pop))) begin
      wr_data_d = word;
    end else if (pop && (count_q > CNT_W'(1))) begin
      wr_data_d = mem_q[rd_ptr_d];
    end

    if (accept && illegal) begin
      err_d = 1'b1;
    end

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          state_d   = S_LOAD;
          wr_addr_d = base_addr_i;
          icount_d  = '0;
          err_d     = 1'b0;
          wr_ptr_d  = '0;
          rd_ptr_d  = '0;
          count_d   = '0;
        end
      end
      S_LOAD: begin
        if (accept && in_last_i) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (count_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      icount_q  <= '0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      icount_q  <= icount_d;
      err_q     <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= word;
    end
  end

endmodule
